mem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction-fetch stage and the MEM stage of the OpenMIPS pipeline. It grants one shared Wishbone-style bus to one requester at a time, handles variable-latency bus acknowledgements, and raises per-stage stall requests that `ctrl` combines into the `stall` vector. It also discards fetch results after a pipeline flush and aborts bus cycles that never complete.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the shared bus and mem_arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment's view.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        flush_i;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        err_o;

  modport master (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  flush_i, bus_rdata_i, bus_ack_i,
    output if_data_o, if_ack_o, mem_rdata_o, mem_ack_o, bus_cyc_o, bus_stb_o, bus_we_o,
    output bus_sel_o, bus_addr_o, bus_wdata_o, stallreq_if_o, stallreq_mem_o, err_o
  );

  modport slave (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output flush_i, bus_rdata_i, bus_ack_i,
    input  if_data_o, if_ack_o, mem_rdata_o, mem_ack_o, bus_cyc_o, bus_stb_o, bus_we_o,
    input  bus_sel_o, bus_addr_o, bus_wdata_o, stallreq_if_o, stallreq_mem_o, err_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one Wishbone-style bus between instruction fetch and the MEM stage: round-robin
// tie-break, fetch discard after a pipeline flush, and abort of accesses that never ack.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master arb
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIfAcc  = 2'd1;
  localparam logic [1:0] StMemAcc = 2'd2;
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_mem_q, last_mem_d;
  logic        discard_q, discard_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic        err_q, err_d;

  logic        mem_elig, if_elig, grant_mem;
  logic        timed_out, done, drop_fetch;
  logic [31:0] rsp_data;

  // A requester is masked in its own ack cycle so a held request is not re-granted.
  assign mem_elig  = arb.mem_req_i & ~mem_ack_q;
  assign if_elig   = arb.if_req_i & ~if_ack_q & ~arb.flush_i;
  assign grant_mem = mem_elig & (~if_elig | ~last_mem_q);

  // Ack in the cycle the counter reaches the limit still counts as success.
  assign timed_out = ~arb.bus_ack_i & (cnt_q == TimeoutCnt);
  assign done      = arb.bus_ack_i | timed_out;
  assign rsp_data  = arb.bus_ack_i ? arb.bus_rdata_i : 32'h0;
  // A flush arriving in the completing cycle cancels the fetch as well.
  assign drop_fetch = discard_q | arb.flush_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_mem_d  = last_mem_q;
    discard_d   = discard_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_mem) begin
          state_d    = StMemAcc;
          cyc_d      = 1'b1;
          we_d       = arb.mem_we_i;
          sel_d      = arb.mem_sel_i;
          addr_d     = arb.mem_addr_i;
          wdata_d    = arb.mem_wdata_i;
          cnt_d      = 8'd0;
          last_mem_d = 1'b1;
        end else if (if_elig) begin
          state_d    = StIfAcc;
          cyc_d      = 1'b1;
          we_d       = 1'b0;
          sel_d      = 4'hF;
          addr_d     = arb.if_addr_i;
          wdata_d    = 32'h0;
          cnt_d      = 8'd0;
          last_mem_d = 1'b0;
        end
      end
      StIfAcc, StMemAcc: begin
        if (done) begin
          state_d   = StIdle;
          cyc_d     = 1'b0;
          err_d     = timed_out;
          discard_d = 1'b0;
          if (state_q == StIfAcc) begin
            if (!drop_fetch) begin
              if_ack_d  = 1'b1;
              if_data_d = rsp_data;
            end
          end else begin
            mem_ack_d = 1'b1;
            if (!we_q || timed_out) mem_rdata_d = rsp_data;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (state_q == StIfAcc && arb.flush_i) discard_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      last_mem_q  <= 1'b0;
      discard_q   <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_mem_q  <= last_mem_d;
      discard_q   <= discard_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
  end

  assign arb.bus_cyc_o      = cyc_q;
  assign arb.bus_stb_o      = cyc_q;
  assign arb.bus_we_o       = we_q;
  assign arb.bus_sel_o      = sel_q;
  assign arb.bus_addr_o     = addr_q;
  assign arb.bus_wdata_o    = wdata_q;
  assign arb.if_data_o      = if_data_q;
  assign arb.if_ack_o       = if_ack_q;
  assign arb.mem_rdata_o    = mem_rdata_q;
  assign arb.mem_ack_o      = mem_ack_q;
  assign arb.err_o          = err_q;
  assign arb.stallreq_if_o  = arb.if_req_i & ~if_ack_q;
  assign arb.stallreq_mem_o = arb.mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned TO = 4;
  localparam int OwnNone = 0;
  localparam int OwnIf   = 1;
  localparam int OwnMem  = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mem_arbiter_if ifc ();

  mem_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b required %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: who owns the bus, when the access started, and its outcome.
  int unsigned tick;
  int unsigned start;
  int          owner;
  logic        m_valid;
  logic        last_mem;
  logic        cancelled;
  logic        e_cyc, e_we, e_if_ack, e_mem_ack, e_err;
  logic [3:0]  e_sel;
  logic [31:0] e_addr, e_wdata, e_if_data, e_mem_rdata;

  task automatic model_step();
    int unsigned now;
    logic want_if, want_mem, timed, nif, nmem, nerr;
    logic [31:0] d;
    now  = tick;
    tick = tick + 1;
    nif  = 1'b0;
    nmem = 1'b0;
    nerr = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      owner = OwnNone; last_mem = 1'b0; cancelled = 1'b0;
      e_cyc = 1'b0; e_we = 1'b0; e_sel = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
      e_if_data = 32'h0; e_mem_rdata = 32'h0;
    end else if (owner == OwnNone) begin
      want_mem = ifc.mem_req_i && !e_mem_ack;
      want_if  = ifc.if_req_i && !e_if_ack && !ifc.flush_i;
      if (want_mem && !(want_if && last_mem)) begin
        owner = OwnMem;
        e_we = ifc.mem_we_i; e_sel = ifc.mem_sel_i;
        e_addr = ifc.mem_addr_i; e_wdata = ifc.mem_wdata_i;
      end else if (want_if) begin
        owner = OwnIf;
        e_we = 1'b0; e_sel = 4'hF; e_addr = ifc.if_addr_i;
      end
      if (owner != OwnNone) begin
        e_cyc = 1'b1;
        start = now + 1;
        cancelled = 1'b0;
        last_mem = (owner == OwnMem);
      end
    end else begin
      if (owner == OwnIf && ifc.flush_i) cancelled = 1'b1;
      if (ifc.bus_ack_i || (now - start) == TO) begin
        timed = !ifc.bus_ack_i;
        d = timed ? 32'h0 : ifc.bus_rdata_i;
        nerr = timed;
        if (owner == OwnIf && !cancelled) begin
          nif = 1'b1;
          e_if_data = d;
        end
        if (owner == OwnMem) begin
          nmem = 1'b1;
          if (timed || !e_we) e_mem_rdata = d;
        end
        e_cyc = 1'b0;
        owner = OwnNone;
      end
    end
    e_if_ack  = nif;
    e_mem_ack = nmem;
    e_err     = nerr;
  endtask

  initial begin
    tick = 0; start = 0; owner = OwnNone; m_valid = 1'b0;
    last_mem = 1'b0; cancelled = 1'b0;
    e_cyc = 1'b0; e_we = 1'b0; e_if_ack = 1'b0; e_mem_ack = 1'b0; e_err = 1'b0;
    e_sel = 4'h0; e_addr = 32'h0; e_wdata = 32'h0; e_if_data = 32'h0; e_mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk1("cyc", ifc.bus_cyc_o, e_cyc);
        chk1("stb", ifc.bus_stb_o, e_cyc);
        chk1("if_ack", ifc.if_ack_o, e_if_ack);
        chk1("mem_ack", ifc.mem_ack_o, e_mem_ack);
        chk1("err", ifc.err_o, e_err);
        chk32("if_data", ifc.if_data_o, e_if_data);
        chk32("mem_rdata", ifc.mem_rdata_o, e_mem_rdata);
        chk1("stall_if", ifc.stallreq_if_o, ifc.if_req_i & ~e_if_ack);
        chk1("stall_mem", ifc.stallreq_mem_o, ifc.mem_req_i & ~e_mem_ack);
        if (e_cyc) begin
          chk1("bus_we", ifc.bus_we_o, e_we);
          chk32("bus_sel", 32'(ifc.bus_sel_o), 32'(e_sel));
          chk32("bus_addr", ifc.bus_addr_o, e_addr);
          if (owner == OwnMem) chk32("bus_wdata", ifc.bus_wdata_o, e_wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    ifc.if_req_i = 1'b0; ifc.if_addr_i = 32'h0;
    ifc.mem_req_i = 1'b0; ifc.mem_we_i = 1'b0; ifc.mem_sel_i = 4'h0;
    ifc.mem_addr_i = 32'h0; ifc.mem_wdata_i = 32'h0;
    ifc.flush_i = 1'b0; ifc.bus_ack_i = 1'b0; ifc.bus_rdata_i = 32'h0;
  endtask

  task automatic mem_load(input logic [31:0] addr);
    ifc.mem_req_i = 1'b1; ifc.mem_we_i = 1'b0; ifc.mem_sel_i = 4'hF;
    ifc.mem_addr_i = addr; ifc.mem_wdata_i = 32'h0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    clear_inputs();
    step(); step();
    settle();
    chk1("rst_cyc", ifc.bus_cyc_o, 1'b0);
    chk32("rst_addr", ifc.bus_addr_o, 32'h0);
    chk32("rst_if_data", ifc.if_data_o, 32'h0);
    chk1("rst_err", ifc.err_o, 1'b0);
    rst = 1'b0;
    step();

    // Single zero-wait fetch.
    ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h0000_0040;
    settle(); chk1("s1_stall_c0", ifc.stallreq_if_o, 1'b1); chk1("s1_stb_c0", ifc.bus_stb_o, 1'b0);
    step(); ifc.bus_ack_i = 1'b1; ifc.bus_rdata_i = 32'h3401_1100;
    settle(); chk1("s1_stb_c1", ifc.bus_stb_o, 1'b1); chk32("s1_addr", ifc.bus_addr_o, 32'h40);
    chk1("s1_stall_c1", ifc.stallreq_if_o, 1'b1);
    step(); ifc.bus_ack_i = 1'b0;
    settle(); chk1("s1_ack_c2", ifc.if_ack_o, 1'b1);
    chk32("s1_data", ifc.if_data_o, 32'h3401_1100); chk1("s1_stall_c2", ifc.stallreq_if_o, 1'b0);
    step(); ifc.if_req_i = 1'b0;
    settle(); chk1("s1_ack_c3", ifc.if_ack_o, 1'b0);

    // IF and MEM tie with a 2-cycle bus wait: MEM first.
    ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h44; mem_load(32'h200);
    step(); settle(); chk32("s2_first", ifc.bus_addr_o, 32'h200);
    step();
    step(); ifc.bus_ack_i = 1'b1; ifc.bus_rdata_i = 32'h1111_2222;
    settle(); chk1("s2_mack_c3", ifc.mem_ack_o, 1'b0);
    step(); ifc.bus_ack_i = 1'b0;
    settle(); chk1("s2_mack_c4", ifc.mem_ack_o, 1'b1);
    chk32("s2_mdata", ifc.mem_rdata_o, 32'h1111_2222); chk1("s2_dead_c4", ifc.bus_stb_o, 1'b0);
    step(); ifc.mem_req_i = 1'b0;
    settle(); chk1("s2_stb_c5", ifc.bus_stb_o, 1'b1); chk32("s2_second", ifc.bus_addr_o, 32'h44);
    step();
    step(); ifc.bus_ack_i = 1'b1; ifc.bus_rdata_i = 32'h2222_3333;
    step(); ifc.bus_ack_i = 1'b0;
    settle(); chk1("s2_iack_c8", ifc.if_ack_o, 1'b1); chk32("s2_idata", ifc.if_data_o, 32'h2222_3333);
    step(); ifc.if_req_i = 1'b0;

    // Store: bus mirrors the request, load data register untouched.
    ifc.mem_req_i = 1'b1; ifc.mem_we_i = 1'b1; ifc.mem_sel_i = 4'b0011;
    ifc.mem_addr_i = 32'h100; ifc.mem_wdata_i = 32'hDEAD_BEEF;
    step(); ifc.bus_ack_i = 1'b1; ifc.bus_rdata_i = 32'hCAFE_F00D;
    settle(); chk1("s3_we", ifc.bus_we_o, 1'b1); chk32("s3_sel", 32'(ifc.bus_sel_o), 32'h3);
    chk32("s3_addr", ifc.bus_addr_o, 32'h100); chk32("s3_wdata", ifc.bus_wdata_o, 32'hDEAD_BEEF);
    step(); ifc.bus_ack_i = 1'b0;
    settle(); chk1("s3_ack", ifc.mem_ack_o, 1'b1); chk32("s3_rdata", ifc.mem_rdata_o, 32'h1111_2222);
    step(); ifc.mem_req_i = 1'b0; ifc.mem_we_i = 1'b0;

    // Tie again after a MEM grant: IF wins.
    ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h48; mem_load(32'h204);
    step(); ifc.bus_ack_i = 1'b1; ifc.bus_rdata_i = 32'h3C1C_1000;
    settle(); chk32("s2b_first", ifc.bus_addr_o, 32'h48);
    step(); ifc.bus_ack_i = 1'b0;
    settle(); chk1("s2b_iack", ifc.if_ack_o, 1'b1);
    step(); ifc.if_req_i = 1'b0; ifc.bus_ack_i = 1'b1; ifc.bus_rdata_i = 32'h55;
    settle(); chk32("s2b_second", ifc.bus_addr_o, 32'h204);
    step(); ifc.bus_ack_i = 1'b0;
    settle(); chk1("s2b_mack", ifc.mem_ack_o, 1'b1);
    step(); ifc.mem_req_i = 1'b0;

    // Flush mid-fetch: cycle completes, result discarded.
    ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h80;
    step(); settle(); chk1("s4_stb_c1", ifc.bus_stb_o, 1'b1);
    step(); ifc.flush_i = 1'b1;
    step(); ifc.flush_i = 1'b0; ifc.if_req_i = 1'b0;
    ifc.bus_ack_i = 1'b1; ifc.bus_rdata_i = 32'hBAD0_BAD0;
    settle(); chk1("s4_stb_c3", ifc.bus_stb_o, 1'b1);
    step(); ifc.bus_ack_i = 1'b0;
    settle(); chk1("s4_stb_c4", ifc.bus_stb_o, 1'b0); chk1("s4_ack_c4", ifc.if_ack_o, 1'b0);
    chk32("s4_data", ifc.if_data_o, 32'h3C1C_1000);
    step(); settle(); chk1("s4_ack_c5", ifc.if_ack_o, 1'b0);

    // Timeout on a load with no bus ack.
    mem_load(32'h300);
    for (int c = 1; c <= 5; c++) step();
    settle(); chk1("s5_cyc_c5", ifc.bus_cyc_o, 1'b1); chk1("s5_err_c5", ifc.err_o, 1'b0);
    step();
    settle(); chk1("s5_err_c6", ifc.err_o, 1'b1); chk1("s5_ack_c6", ifc.mem_ack_o, 1'b1);
    chk32("s5_rdata", ifc.mem_rdata_o, 32'h0); chk1("s5_cyc_c6", ifc.bus_cyc_o, 1'b0);
    step(); ifc.mem_req_i = 1'b0;
    settle(); chk1("s5_err_c7", ifc.err_o, 1'b0);

    // Reset in the middle of an access; held request is re-granted.
    mem_load(32'h304);
    step(); settle(); chk1("s6_stb_c1", ifc.bus_stb_o, 1'b1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    settle(); chk1("s6_cyc_c3", ifc.bus_cyc_o, 1'b0); chk32("s6_addr", ifc.bus_addr_o, 32'h0);
    chk32("s6_if_data", ifc.if_data_o, 32'h0); chk1("s6_mack_c3", ifc.mem_ack_o, 1'b0);
    chk1("s6_err_c3", ifc.err_o, 1'b0);
    step(); ifc.bus_ack_i = 1'b1; ifc.bus_rdata_i = 32'h0BAD_F00D;
    settle(); chk1("s6_regrant", ifc.bus_stb_o, 1'b1); chk32("s6_addr2", ifc.bus_addr_o, 32'h304);
    step(); ifc.bus_ack_i = 1'b0;
    settle(); chk1("s6_mack_c5", ifc.mem_ack_o, 1'b1);
    step(); ifc.mem_req_i = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 4000 && n_err < 100; i++) begin
      step();
      rst = ($urandom_range(0, 399) == 0);
      ifc.flush_i = ($urandom_range(0, 11) == 0);
      if (!ifc.if_req_i || ifc.if_ack_o) begin
        ifc.if_req_i  = ($urandom_range(0, 2) != 0);
        ifc.if_addr_i = $urandom() & 32'hFFFF_FFFC;
      end else if (ifc.flush_i) begin
        ifc.if_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      if (!ifc.mem_req_i || ifc.mem_ack_o) begin
        ifc.mem_req_i   = ($urandom_range(0, 2) != 0);
        ifc.mem_we_i    = ($urandom_range(0, 1) == 1);
        ifc.mem_sel_i   = 4'($urandom_range(1, 15));
        ifc.mem_addr_i  = $urandom();
        ifc.mem_wdata_i = $urandom();
      end
      ifc.bus_ack_i   = ($urandom_range(0, 99) < ((i < 2000) ? 60 : 20));
      ifc.bus_rdata_i = $urandom();
    end

    rst = 1'b0;
    clear_inputs();
    ifc.bus_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ifc.bus_ack_i = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
